// File: rtl/score_counter_bcd.sv
// Saturating 0..999 score accumulator; the displayed BCD score rolls toward the
// awarded total one step (+1 or +10) per frame tick.
module score_counter_bcd #(
    parameter int unsigned FAST_THRESHOLD = 20,
    parameter int unsigned MAX_SCORE      = 999
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            addReq,
    input  logic [6:0]      addValue,
    input  logic            clearScore,
    input  logic            rollTick,
    output logic [2:0][3:0] numbersToShow,
    output logic            busy,
    output logic            maxed
);

    localparam int unsigned BW = 10;
    localparam int unsigned SW = 11;
    localparam int unsigned VW = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROLL = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [2:0][3:0] disp_bcd, disp_bcd_next;
    logic [BW-1:0]   disp_bin, disp_bin_next;
    logic [BW-1:0]   pending, pending_next;

    logic            do_step;
    logic [3:0]      step;
    logic [VW-1:0]   add_clamped;
    logic [3:0]      ones_raw, tens_raw, ones_sum, tens_sum, hund_sum;
    logic            carry_ones, carry_tens;
    logic [SW-1:0]   rolled, award_sum, award_cap;

    // Step selection, decimal carry chain and pending/state update.
    always_comb begin
        state_next    = state;
        disp_bcd_next = disp_bcd;
        disp_bin_next = disp_bin;
        pending_next  = pending;
        award_sum     = '0;
        award_cap     = '0;

        add_clamped = (addValue > VW'(99)) ? VW'(99) : addValue;
        do_step     = rollTick && (pending != '0);
        step        = 4'd0;
        if (do_step) begin
            step = (pending >= BW'(FAST_THRESHOLD)) ? 4'd10 : 4'd1;
        end

        // 4 bits suffice: a digit plus carry-in plus one never exceeds 11.
        ones_raw   = disp_bcd[0] + 4'(step == 4'd1);
        carry_ones = (ones_raw > 4'd9);
        ones_sum   = carry_ones ? (ones_raw - 4'd10) : ones_raw;
        tens_raw   = disp_bcd[1] + 4'(carry_ones) + 4'(step == 4'd10);
        carry_tens = (tens_raw > 4'd9);
        tens_sum   = carry_tens ? (tens_raw - 4'd10) : tens_raw;
        hund_sum   = disp_bcd[2] + 4'(carry_tens);

        rolled = SW'(pending) - SW'(step);

        if (clearScore) begin
            disp_bcd_next = '0;
            disp_bin_next = '0;
            pending_next  = '0;
            state_next    = IDLE;
        end else begin
            if (do_step) begin
                disp_bcd_next = {hund_sum, tens_sum, ones_sum};
                disp_bin_next = disp_bin + BW'(step);
            end
            if (addReq && (state != FULL)) begin
                award_sum    = rolled + SW'(add_clamped);
                award_cap    = SW'(MAX_SCORE) - SW'(disp_bin_next);
                pending_next = BW'((award_sum < award_cap) ? award_sum : award_cap);
            end else begin
                pending_next = BW'(rolled);
            end

            if (pending_next != '0) begin
                state_next = ROLL;
            end else if (disp_bin_next == BW'(MAX_SCORE)) begin
                state_next = FULL;
            end else begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state    <= IDLE;
            disp_bcd <= '0;
            disp_bin <= '0;
            pending  <= '0;
            busy     <= 1'b0;
            maxed    <= 1'b0;
        end else begin
            state    <= state_next;
            disp_bcd <= disp_bcd_next;
            disp_bin <= disp_bin_next;
            pending  <= pending_next;
            busy     <= (state_next == ROLL);
            maxed    <= (state_next == FULL);
        end
    end

    assign numbersToShow = disp_bcd;

endmodule

// File: tb/tb_score_counter_bcd.sv
// Bench for score_counter_bcd: directed scenarios plus random traffic checked
// against an integer model of the award/roll rules.
module tb_score_counter_bcd;

    logic            clk = 1'b0;
    logic            resetN = 1'b0;
    logic            addReq = 1'b0;
    logic [6:0]      addValue = '0;
    logic            clearScore = 1'b0;
    logic            rollTick = 1'b0;
    logic [2:0][3:0] numbersToShow;
    logic            busy;
    logic            maxed;

    int n_cmp = 0;
    int n_err = 0;
    int m_disp = 0;
    int m_pend = 0;

    score_counter_bcd dut (
        .clk          (clk),
        .resetN       (resetN),
        .addReq       (addReq),
        .addValue     (addValue),
        .clearScore   (clearScore),
        .rollTick     (rollTick),
        .numbersToShow(numbersToShow),
        .busy         (busy),
        .maxed        (maxed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, update the model at posedge, compare just after.
    task automatic cycle(input bit rst, input bit add, input int val, input bit clr, input bit tick);
        int step, av, np, cap, exp_bcd;
        @(negedge clk);
        resetN     = !rst;
        addReq     = add;
        addValue   = 7'(val);
        clearScore = clr;
        rollTick   = tick;
        @(posedge clk);
        if (rst || clr) begin
            m_disp = 0;
            m_pend = 0;
        end else begin
            step = 0;
            if (tick && m_pend != 0) step = (m_pend >= 20) ? 10 : 1;
            av = (val > 99) ? 99 : val;
            if (add) begin
                np  = m_pend - step + av;
                cap = 999 - (m_disp + step);
                m_pend = (np < cap) ? np : cap;
            end else begin
                m_pend = m_pend - step;
            end
            m_disp = m_disp + step;
        end
        #1;
        exp_bcd = ((m_disp / 100) << 8) | (((m_disp / 10) % 10) << 4) | (m_disp % 10);
        check("display", int'(numbersToShow), exp_bcd);
        check("busy", int'(busy), int'(m_pend != 0));
        check("maxed", int'(maxed), int'(m_disp == 999 && m_pend == 0));
        check("pending", int'(dut.pending), m_pend);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 1);
    endtask

    initial begin
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Small award, +1 steps.
        cycle(0, 1, 5, 0, 0);
        ticks(5);
        // Fast roll then slow roll: 18 ticks settle 45 points.
        cycle(0, 1, 45, 0, 0);
        ticks(18);
        check("settled_50", int'(numbersToShow), 12'h050);

        // Carry 099 -> 100.
        cycle(0, 1, 50, 0, 0);
        ticks(13);
        check("pre_carry", int'(numbersToShow), 12'h099);
        ticks(1);
        check("carry_100", int'(numbersToShow), 12'h100);
        check("carry_bin", int'(dut.disp_bin), 100);

        // Saturation: settle at 990, then award 30 and 7.
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 99, 0, 0);
            ticks(40);
        end
        check("at_990", int'(numbersToShow), 12'h990);
        cycle(0, 1, 30, 0, 0);
        check("sat_pending", int'(dut.pending), 9);
        ticks(9);
        check("sat_maxed", int'(maxed), 1);
        cycle(0, 1, 7, 0, 0);
        ticks(2);
        check("full_ignore", int'(dut.pending), 0);

        // Simultaneous award and tick, then with clear.
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 13, 0, 0);
        ticks(10);
        cycle(0, 1, 4, 0, 1);
        check("sim_disp", int'(numbersToShow), 12'h011);
        check("sim_pend", int'(dut.pending), 6);
        cycle(0, 1, 4, 1, 1);
        check("clr_disp", int'(numbersToShow), 0);

        // Out-of-contract award clamps to 99.
        cycle(0, 1, 127, 0, 0);
        check("clamp", int'(dut.pending), 99);

        // Reset mid-roll.
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 75, 0, 0);
        ticks(5);
        check("mid_disp", int'(numbersToShow), 12'h050);
        cycle(1, 0, 0, 0, 1);
        ticks(3);

        // Random traffic: frequent clears, then long runs that reach saturation.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 127)), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 1) == 1));
        end
        for (int i = 0; i < 6000; i++) begin
            cycle(($urandom_range(0, 1999) == 0), ($urandom_range(0, 2) == 0),
                  int'($urandom_range(0, 127)), ($urandom_range(0, 799) == 0),
                  ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
